// File: rtl/instruction_arbiter.sv
// -----------------------------------------------------------------------------
// instruction_arbiter
//   Shares one DATA_W-bit SPI instruction sender between N_REQ instruction
//   sources. Pending requests are granted round-robin, pushed to the sender
//   over its WR/DATA/BUSY interface, and the source is told the outcome with a
//   one-cycle ACK (sender took the word) or ERR (sender never raised BUSY
//   within TIMEOUT cycles of WR).
//
// Ports
//   CLK       in   system clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   REQ       in   per-requester request level, held until ACK/ERR
//   REQ_DATA  in   per-requester instruction, requester i at [i*DATA_W +: DATA_W]
//   ACK       out  one-cycle pulse, word from requester i accepted
//   ERR       out  one-cycle pulse, word from requester i dropped on timeout
//   CUR_ID    out  requester being served, valid while ACTIVE
//   ACTIVE    out  high while issuing or waiting for the sender to go ready
//   WR        out  write strobe to the sender
//   DATA      out  instruction to the sender, holds the last word while idle
//   BUSY      in   sender busy, low when a word can be accepted
// -----------------------------------------------------------------------------
module instruction_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                      CLK,
   input  logic                      RESET_N,
   input  logic [N_REQ-1:0]          REQ,
   input  logic [N_REQ*DATA_W-1:0]   REQ_DATA,
   output logic [N_REQ-1:0]          ACK,
   output logic [N_REQ-1:0]          ERR,
   output logic [2:0]                CUR_ID,
   output logic                      ACTIVE,
   output logic                      WR,
   output logic [DATA_W-1:0]         DATA,
   input  logic                      BUSY
);

   localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [2:0]       LAST_ID  = 3'(N_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RDY
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          ptr_q, ptr_d;
   logic [2:0]          cur_q, cur_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic                active_q, active_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [N_REQ-1:0]    ack_q, ack_d;
   logic [N_REQ-1:0]    err_q, err_d;

   logic                grant_vld;
   logic [2:0]          grant_id;
   logic [DATA_W-1:0]   grant_data;
   logic [N_REQ-1:0]    cur_onehot;
   logic [2:0]          next_ptr;

   // Round-robin search: first set REQ bit at or above ptr_q, wrapping.
   always_comb begin : rr_search
      logic [N_REQ-1:0] req_rot;
      int unsigned      idx;
      grant_vld = 1'b0;
      grant_id  = '0;
      req_rot   = '0;
      idx       = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx     = (32'(ptr_q) + i) % N_REQ;
         req_rot = REQ >> idx;
         if (!grant_vld && req_rot[0]) begin
            grant_vld = 1'b1;
            grant_id  = 3'(idx);
         end
      end
   end

   assign grant_data = DATA_W'(REQ_DATA >> (32'(grant_id) * DATA_W));
   assign cur_onehot = N_REQ'(1) << cur_q;
   assign next_ptr   = (cur_q == LAST_ID) ? '0 : cur_q + 3'd1;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cur_d    = cur_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      active_d = active_q;
      data_d   = data_q;
      ack_d    = '0;
      err_d    = '0;
      case (state_q)
         ST_IDLE: begin
            if (!BUSY && grant_vld) begin
               cur_d    = grant_id;
               data_d   = grant_data;
               wr_d     = 1'b1;
               active_d = 1'b1;
               cnt_d    = '0;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (BUSY) begin
               wr_d    = 1'b0;
               ack_d   = cur_onehot;
               ptr_d   = next_ptr;
               state_d = ST_WAIT_RDY;
            end else if (cnt_q == CNT_LAST) begin
               wr_d    = 1'b0;
               err_d   = cur_onehot;
               ptr_d   = next_ptr;
               state_d = ST_WAIT_RDY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_RDY: begin
            // Leaving here goes to IDLE without a grant; REQ is looked at
            // again only on the following edge.
            if (!BUSY) begin
               active_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         cur_q    <= '0;
         cnt_q    <= '0;
         wr_q     <= 1'b0;
         active_q <= 1'b0;
         data_q   <= '0;
         ack_q    <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cur_q    <= cur_d;
         cnt_q    <= cnt_d;
         wr_q     <= wr_d;
         active_q <= active_d;
         data_q   <= data_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
      end
   end

   assign ACK    = ack_q;
   assign ERR    = err_q;
   assign CUR_ID = cur_q;
   assign ACTIVE = active_q;
   assign WR     = wr_q;
   assign DATA   = data_q;

endmodule
